// File: rtl/lfsr_rng_pkg.sv
// lfsr_rng_pkg
//   Shared types and constants for the parametrised LFSR random source.
//   - rng_state_t   : request FSM encoding (IDLE, DRAW, HOLD)
//   - LEGAL_WIDTHS  : LFSR widths that have a tap mask
//   - lfsr_taps()   : Fibonacci tap mask for a given width (bit i set = tap on state[i])
//   - is_legal_width(): true when a width has a tap mask
package lfsr_rng_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    HOLD = 2'd2
  } rng_state_t;

  localparam int NUM_LEGAL_WIDTHS = 4;
  localparam int LEGAL_WIDTHS [NUM_LEGAL_WIDTHS] = '{8, 16, 24, 32};

  // Maximal-length masks; returned right-aligned in 32 bits.
  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      8:       return 32'h0000_00B8;
      16:      return 32'h0000_B400;
      24:      return 32'h00E1_0000;
      32:      return 32'hA300_0000;
      default: return 32'h0000_0000;
    endcase
  endfunction

  function automatic bit is_legal_width(input int width);
    for (int i = 0; i < NUM_LEGAL_WIDTHS; i++) begin
      if (LEGAL_WIDTHS[i] == width) return 1'b1;
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/lfsr_rng_param_if.sv
// lfsr_rng_param_if
//   Request/deliver handshake between the game FSM (master) and the random
//   source (slave).
//   req       master->slave  request one value (taken only when the source is idle)
//   limit     master->slave  exclusive upper bound, 0 = unrestricted
//   rnd_ack   master->slave  consumer accepts rnd
//   rnd       slave->master  delivered value, stable while rnd_valid
//   rnd_valid slave->master  rnd holds a delivered value
//   rnd_fail  slave->master  draw budget exhausted, rnd forced to 0
interface lfsr_rng_param_if #(
  parameter int OUT_W = 4
);
  logic             req;
  logic [OUT_W-1:0] limit;
  logic             rnd_ack;
  logic [OUT_W-1:0] rnd;
  logic             rnd_valid;
  logic             rnd_fail;

  modport master (
    output req, limit, rnd_ack,
    input  rnd, rnd_valid, rnd_fail
  );

  modport slave (
    input  req, limit, rnd_ack,
    output rnd, rnd_valid, rnd_fail
  );
endinterface

// File: rtl/btn_edge_sync.sv
// btn_edge_sync
//   Two-flop synchroniser for an asynchronous level, followed by a
//   rising-edge detector. rise_o is a one-cycle pulse, two cycles after the
//   level is first captured.
//   clk    system clock
//   rst    synchronous active-high reset
//   btn_i  asynchronous level input
//   rise_o single-cycle pulse on a synchronised 0->1 transition
module btn_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic rise_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/lfsr_rng_param.sv
// lfsr_rng_param
//   Free-running Fibonacci LFSR random source. A free-running cycle counter
//   is XORed into the state on each debounced button press for player-driven
//   entropy. Values are served over a req/valid/ack handshake, optionally
//   range-limited (value < limit) by rejection sampling.
//
//   Optional feature, macro LFSR_SEED_LOAD_EN: adds seed_load/seed ports that
//   force the LFSR state (seed 0 falls back to SEED_DEFAULT). Without the
//   macro the ports do not exist.
//
//   Ports
//   clk             system clock
//   rst             synchronous active-high reset
//   button_pressed  debounced button level, asynchronous
//   seed_load       (macro only) load seed into the LFSR this cycle
//   seed            (macro only) WIDTH-bit seed value
//   bus             slave side of lfsr_rng_param_if (req/limit/rnd/valid/ack/fail)
//
//   Parameters
//   WIDTH        LFSR width: 8, 16, 24 or 32
//   OUT_W        delivered value width, 1..WIDTH
//   SEED_DEFAULT reset and lock-up recovery state, nonzero after truncation
//   MAX_TRIES    draws per request before giving up, >= 1
//
//   state | meaning
//   IDLE  | waiting for req
//   DRAW  | sampling low LFSR bits, one try per cycle
//   HOLD  | rnd_valid high until rnd_ack
module lfsr_rng_param
  import lfsr_rng_pkg::*;
#(
  parameter int          WIDTH        = 8,
  parameter int          OUT_W        = 4,
  parameter logic [31:0] SEED_DEFAULT = 32'd1,
  parameter int          MAX_TRIES    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               button_pressed,
`ifdef LFSR_SEED_LOAD_EN
  input  logic               seed_load,
  input  logic [WIDTH-1:0]   seed,
`endif
  lfsr_rng_param_if.slave    bus
);

  localparam logic [WIDTH-1:0] TAPS     = WIDTH'(lfsr_taps(WIDTH));
  localparam logic [WIDTH-1:0] SEED     = WIDTH'(SEED_DEFAULT);
  localparam int               TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] lfsr_adv;
  logic [WIDTH-1:0] lfsr_cand;
  logic             btn_rise;

  rng_state_t       state_q, state_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic [OUT_W-1:0] rnd_q, rnd_d;
  logic             fail_q, fail_d;
  logic [OUT_W-1:0] sample;

  btn_edge_sync u_btn (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (button_pressed),
    .rise_o (btn_rise)
  );

  // Later assignments win: seed load over button mix over plain advance.
  always_comb begin
    lfsr_adv  = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
    lfsr_cand = lfsr_adv;
    if (btn_rise) lfsr_cand = lfsr_adv ^ cnt_q;
`ifdef LFSR_SEED_LOAD_EN
    if (seed_load) lfsr_cand = seed;
`endif
    // All-zero is the LFSR's dead state; never let it in.
    lfsr_d = (lfsr_cand == '0) ? SEED : lfsr_cand;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED;
      cnt_q  <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  assign sample = lfsr_q[OUT_W-1:0];

  always_comb begin
    state_d = state_q;
    tries_d = tries_q;
    rnd_d   = rnd_q;
    fail_d  = fail_q;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          state_d = DRAW;
          tries_d = '0;
        end
      end
      DRAW: begin
        if ((bus.limit == '0) || (sample < bus.limit)) begin
          rnd_d   = sample;
          fail_d  = 1'b0;
          state_d = HOLD;
        end else if (tries_q == LAST_TRY) begin
          rnd_d   = '0;
          fail_d  = 1'b1;
          state_d = HOLD;
        end else begin
          tries_d = tries_q + 1'b1;
        end
      end
      HOLD: begin
        if (bus.rnd_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tries_q <= '0;
      rnd_q   <= '0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tries_q <= tries_d;
      rnd_q   <= rnd_d;
      fail_q  <= fail_d;
    end
  end

  assign bus.rnd       = rnd_q;
  assign bus.rnd_valid = (state_q == HOLD);
  assign bus.rnd_fail  = fail_q;

endmodule

// File: tb/tb_lfsr_rng_param.sv
module tb_lfsr_rng_param;
  import lfsr_rng_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       button;
  logic       seed_load;
  logic [7:0] seed;

  int total = 0;
  int bad   = 0;

  // reference model of the LFSR datapath
  logic [7:0] m_state, m_cnt;
  logic       m_s1, m_s2, m_s3;

  lfsr_rng_param_if #(.OUT_W(4)) bus1 ();
  lfsr_rng_param_if #(.OUT_W(4)) bus2 ();

  lfsr_rng_param #(.WIDTH(8), .OUT_W(4), .SEED_DEFAULT(32'd1), .MAX_TRIES(8)) dut1 (
    .clk            (clk),
    .rst            (rst),
    .button_pressed (button),
`ifdef LFSR_SEED_LOAD_EN
    .seed_load      (seed_load),
    .seed           (seed),
`endif
    .bus            (bus1)
  );

  lfsr_rng_param #(.WIDTH(8), .OUT_W(4), .SEED_DEFAULT(32'd1), .MAX_TRIES(2)) dut2 (
    .clk            (clk),
    .rst            (rst),
    .button_pressed (button),
`ifdef LFSR_SEED_LOAD_EN
    .seed_load      (1'b0),
    .seed           (8'h00),
`endif
    .bus            (bus2)
  );

  always #5 clk = ~clk;

  // one clock: update model from current inputs, then land 1 time unit past the edge
  task automatic step();
    logic [7:0] nxt, cand;
    logic       pulse;
    if (rst) begin
      m_state = 8'h01; m_cnt = 8'h00;
      m_s1 = 1'b0; m_s2 = 1'b0; m_s3 = 1'b0;
    end else begin
      nxt   = {m_state[6:0], ^(m_state & 8'hB8)};
      pulse = m_s2 & ~m_s3;
      cand  = nxt;
      if (pulse) cand = nxt ^ m_cnt;
      if (seed_load) cand = seed;
      if (cand == 8'h00) cand = 8'h01;
      m_state = cand;
      m_cnt   = m_cnt + 8'h01;
      m_s3 = m_s2; m_s2 = m_s1; m_s1 = button;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus1.req = 1'b0; bus1.limit = 4'h0; bus1.rnd_ack = 1'b0;
    bus2.req = 1'b0; bus2.limit = 4'h0; bus2.rnd_ack = 1'b0;
    button = 1'b0; seed_load = 1'b0; seed = 8'h00;
  endtask

  // after this, the current cycle holds state 0x01 with counter 0
  task automatic apply_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] exp_seq [7];
    exp_seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47};
    idle_inputs();
    apply_reset();
    total++; if (bus1.rnd_valid !== 1'b0 || bus1.rnd !== 4'h0 || bus1.rnd_fail !== 1'b0) begin
      bad++; $display("FAIL reset_outputs: valid=%0b rnd=%h fail=%0b want 0/0/0", bus1.rnd_valid, bus1.rnd, bus1.rnd_fail);
    end
    // reach HOLD, then reset mid-HOLD
    bus1.req = 1'b1; step(); bus1.req = 1'b0; step();
    rst = 1'b1; step(); rst = 1'b0;
    total++; if (bus1.rnd_valid !== 1'b0 || bus1.rnd !== 4'h0 || bus1.rnd_fail !== 1'b0) begin
      bad++; $display("FAIL reset_mid_hold: valid=%0b rnd=%h fail=%0b want 0/0/0", bus1.rnd_valid, bus1.rnd, bus1.rnd_fail);
    end
    total++; if (dut1.state_q !== IDLE) begin
      bad++; $display("FAIL reset_fsm_idle: got %0d want %0d", dut1.state_q, IDLE);
    end
    for (int i = 0; i < 7; i++) begin
      total++; if (dut1.lfsr_q !== exp_seq[i]) begin
        bad++; $display("FAIL reset_lfsr_seq[%0d]: got %h want %h", i, dut1.lfsr_q, exp_seq[i]);
      end
      step();
    end
    // reset during DRAW: no delivery afterwards
    apply_reset();
    bus1.req = 1'b1; step(); bus1.req = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    step();
    total++; if (bus1.rnd_valid !== 1'b0) begin
      bad++; $display("FAIL reset_mid_draw: valid got %0b want 0", bus1.rnd_valid);
    end
  endtask

  task automatic test_unrestricted();
    idle_inputs();
    apply_reset();
    bus1.req = 1'b1; step(); bus1.req = 1'b0;
    total++; if (bus1.rnd_valid !== 1'b0) begin
      bad++; $display("FAIL unres_early_valid: got %0b want 0", bus1.rnd_valid);
    end
    step();
    for (int i = 0; i < 5; i++) begin
      total++; if (bus1.rnd_valid !== 1'b1 || bus1.rnd !== 4'h2 || bus1.rnd_fail !== 1'b0) begin
        bad++; $display("FAIL unres_hold[%0d]: valid=%0b rnd=%h fail=%0b want 1/2/0", i, bus1.rnd_valid, bus1.rnd, bus1.rnd_fail);
      end
      if (i < 4) step();
    end
    bus1.rnd_ack = 1'b1; step(); bus1.rnd_ack = 1'b0;
    total++; if (bus1.rnd_valid !== 1'b0) begin
      bad++; $display("FAIL unres_after_ack: valid got %0b want 0", bus1.rnd_valid);
    end
  endtask

  task automatic test_rejection();
    idle_inputs();
    apply_reset();
    bus1.limit = 4'h2;
    bus1.req = 1'b1; step(); bus1.req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++; if (bus1.rnd_valid !== 1'b0) begin
        bad++; $display("FAIL reject_wait[%0d]: valid got %0b want 0", i, bus1.rnd_valid);
      end
      step();
    end
    total++; if (bus1.rnd_valid !== 1'b1 || bus1.rnd !== 4'h1 || bus1.rnd_fail !== 1'b0) begin
      bad++; $display("FAIL reject_deliver: valid=%0b rnd=%h fail=%0b want 1/1/0", bus1.rnd_valid, bus1.rnd, bus1.rnd_fail);
    end
    bus1.rnd_ack = 1'b1; step(); bus1.rnd_ack = 1'b0;
    // limit 3: first sample 2 is inside the range
    apply_reset();
    bus1.limit = 4'h3;
    bus1.req = 1'b1; step(); bus1.req = 1'b0; step();
    total++; if (bus1.rnd_valid !== 1'b1 || bus1.rnd !== 4'h2) begin
      bad++; $display("FAIL limit3_deliver: valid=%0b rnd=%h want 1/2", bus1.rnd_valid, bus1.rnd);
    end
    bus1.rnd_ack = 1'b1; step(); bus1.rnd_ack = 1'b0;
  endtask

  task automatic test_exhaustion();
    idle_inputs();
    apply_reset();
    bus2.limit = 4'h1;
    bus2.req = 1'b1; step(); bus2.req = 1'b0; step();
    total++; if (bus2.rnd_valid !== 1'b0) begin
      bad++; $display("FAIL exhaust_wait: valid got %0b want 0", bus2.rnd_valid);
    end
    step();
    total++; if (bus2.rnd_valid !== 1'b1 || bus2.rnd !== 4'h0 || bus2.rnd_fail !== 1'b1) begin
      bad++; $display("FAIL exhaust_deliver: valid=%0b rnd=%h fail=%0b want 1/0/1", bus2.rnd_valid, bus2.rnd, bus2.rnd_fail);
    end
    bus2.rnd_ack = 1'b1; step(); bus2.rnd_ack = 1'b0;
  endtask

  task automatic test_button();
    idle_inputs();
    apply_reset();
    button = 1'b1; step(); step();
    // edge pulse now: state 0x04, counter 2 -> 0x08 ^ 0x02
    bus1.req = 1'b1; step(); bus1.req = 1'b0;
    total++; if (dut1.lfsr_q !== 8'h0A) begin
      bad++; $display("FAIL button_mix_state: got %h want 0a", dut1.lfsr_q);
    end
    step();
    total++; if (bus1.rnd_valid !== 1'b1 || bus1.rnd !== 4'hA) begin
      bad++; $display("FAIL button_mix_draw: valid=%0b rnd=%h want 1/a", bus1.rnd_valid, bus1.rnd);
    end
    button = 1'b0;
    bus1.rnd_ack = 1'b1; step(); bus1.rnd_ack = 1'b0;
  endtask

`ifdef LFSR_SEED_LOAD_EN
  task automatic test_lockup();
    idle_inputs();
    apply_reset();
    for (int i = 0; i < 14; i++) step();
    button = 1'b1; step();
    // next(0x88) = 0x10 matches counter 16 in the pulse cycle
    seed_load = 1'b1; seed = 8'h88; step(); seed_load = 1'b0;
    total++; if (dut1.lfsr_q !== 8'h88) begin
      bad++; $display("FAIL seed_load_value: got %h want 88", dut1.lfsr_q);
    end
    step();
    total++; if (dut1.lfsr_q !== 8'h01) begin
      bad++; $display("FAIL lockup_recover: got %h want 01", dut1.lfsr_q);
    end
    button = 1'b0;
    seed_load = 1'b1; seed = 8'h00; step(); seed_load = 1'b0;
    total++; if (dut1.lfsr_q !== 8'h01) begin
      bad++; $display("FAIL seed_zero: got %h want 01", dut1.lfsr_q);
    end
  endtask
`endif

  task automatic test_misuse();
    idle_inputs();
    apply_reset();
    bus1.req = 1'b1;
    step(); step(); step();
    total++; if (bus1.rnd_valid !== 1'b1 || bus1.rnd !== 4'h2) begin
      bad++; $display("FAIL misuse_hold_req: valid=%0b rnd=%h want 1/2", bus1.rnd_valid, bus1.rnd);
    end
    bus1.rnd_ack = 1'b1; step(); bus1.rnd_ack = 1'b0;
    total++; if (bus1.rnd_valid !== 1'b0) begin
      bad++; $display("FAIL misuse_idle: valid got %0b want 0", bus1.rnd_valid);
    end
    step();
    total++; if (bus1.rnd_valid !== 1'b0) begin
      bad++; $display("FAIL misuse_draw: valid got %0b want 0", bus1.rnd_valid);
    end
    step();
    total++; if (bus1.rnd_valid !== 1'b1 || bus1.rnd !== 4'h3) begin
      bad++; $display("FAIL misuse_redeliver: valid=%0b rnd=%h want 1/3", bus1.rnd_valid, bus1.rnd);
    end
    bus1.req = 1'b0;
    bus1.rnd_ack = 1'b1; step(); bus1.rnd_ack = 1'b0;
    // ack while idle does nothing
    apply_reset();
    bus1.rnd_ack = 1'b1; step(); step(); step(); bus1.rnd_ack = 1'b0;
    total++; if (bus1.rnd_valid !== 1'b0 || dut1.state_q !== IDLE) begin
      bad++; $display("FAIL ack_in_idle: valid=%0b state=%0d want 0/%0d", bus1.rnd_valid, dut1.state_q, IDLE);
    end
    bus1.req = 1'b1; step(); bus1.req = 1'b0; step();
    total++; if (bus1.rnd_valid !== 1'b1 || bus1.rnd !== 4'h1) begin
      bad++; $display("FAIL ack_in_idle_then_req: valid=%0b rnd=%h want 1/1", bus1.rnd_valid, bus1.rnd);
    end
    bus1.rnd_ack = 1'b1; step(); bus1.rnd_ack = 1'b0;
  endtask

  task automatic test_random();
    bit stop = 1'b0;
    idle_inputs();
    apply_reset();
    for (int i = 0; i < 10000 && !stop; i++) begin
      if ($urandom_range(0, 5) == 0) button = ~button;
`ifdef LFSR_SEED_LOAD_EN
      seed_load = ($urandom_range(0, 63) == 0);
      seed = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
`endif
      bus1.req     = $urandom_range(0, 1);
      bus1.limit   = 4'($urandom_range(0, 15));
      bus1.rnd_ack = $urandom_range(0, 1);
      step();
      total++;
      if (dut1.lfsr_q !== m_state || dut1.lfsr_q === 8'h00) begin
        bad++; stop = 1'b1;
        $display("FAIL random_state cycle %0d: got %h want %h", i, dut1.lfsr_q, m_state);
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_unrestricted();
    test_rejection();
    test_exhaustion();
    test_button();
`ifdef LFSR_SEED_LOAD_EN
    test_lockup();
`endif
    test_misuse();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
